// File: rtl/fft_butterfly_pipe_if.sv
// Operand/twiddle input stream and butterfly result stream of fft_butterfly_pipe.
// The master drives operands and consumes results; the slave is the butterfly.
interface fft_butterfly_pipe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TW_W   = 8,
    parameter int unsigned CNT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a_re;
    logic signed [DATA_W-1:0] a_im;
    logic signed [DATA_W-1:0] b_re;
    logic signed [DATA_W-1:0] b_im;
    logic signed [TW_W-1:0]   w_re;
    logic signed [TW_W-1:0]   w_im;
    logic                     scale_en;
    logic                     clr_ovf;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] y_re;
    logic signed [DATA_W-1:0] y_im;
    logic signed [DATA_W-1:0] z_re;
    logic signed [DATA_W-1:0] z_im;
    logic                     ovf;
    logic                     ovf_sticky;
    logic [CNT_W-1:0]         out_count;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, scale_en, clr_ovf, out_ready,
        input  in_ready, out_valid, y_re, y_im, z_re, z_im, ovf, ovf_sticky, out_count
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, scale_en, clr_ovf, out_ready,
        output in_ready, out_valid, y_re, y_im, z_re, z_im, ovf, ovf_sticky, out_count
    );
endinterface

// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: y = a + W*b, z = a - W*b, one per clock.
// Three stages (multiply, round, add/scale/saturate) stall together when the output is blocked.
module fft_butterfly_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TW_W   = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    fft_butterfly_pipe_if.slave bus
);
    localparam int unsigned PW = DATA_W + TW_W + 1;
    localparam int unsigned SW = DATA_W + 2;
    localparam logic signed [PW-1:0] RND = PW'(1) << (TW_W - 2);

    logic                     v1_q, v1_d, sc1_q, sc1_d;
    logic signed [DATA_W-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
    logic signed [PW-1:0]     p1_re_q, p1_re_d, p1_im_q, p1_im_d;
    logic                     v2_q, v2_d, sc2_q, sc2_d;
    logic signed [DATA_W-1:0] a2_re_q, a2_re_d, a2_im_q, a2_im_d;
    logic signed [SW-1:0]     p2_re_q, p2_re_d, p2_im_q, p2_im_d;
    logic                     v3_q, v3_d, ovf_q, ovf_d;
    logic signed [DATA_W-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
    logic signed [DATA_W-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
    logic                     sticky_q, sticky_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic                     adv_c, out_xfer_c;
    logic signed [PW-1:0]     m_rr, m_ii, m_ri, m_ir;
    logic signed [SW-1:0]     s_yr, s_yi, s_zr, s_zi;
    logic                     o_yr, o_yi, o_zr, o_zi;

    // Clamp to DATA_W bits; MSB of the result flags saturation.
    function automatic logic [DATA_W:0] sat(input logic signed [SW-1:0] x);
        logic [SW-DATA_W:0] top;
        top = x[SW-1:DATA_W-1];
        if ((top != '0) && (top != '1)) begin
            return x[SW-1] ? {1'b1, 1'b1, {(DATA_W-1){1'b0}}}
                           : {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end
        return {1'b0, x[DATA_W-1:0]};
    endfunction

    always_comb begin
        v1_d = v1_q;  sc1_d = sc1_q;
        a1_re_d = a1_re_q;  a1_im_d = a1_im_q;
        p1_re_d = p1_re_q;  p1_im_d = p1_im_q;
        v2_d = v2_q;  sc2_d = sc2_q;
        a2_re_d = a2_re_q;  a2_im_d = a2_im_q;
        p2_re_d = p2_re_q;  p2_im_d = p2_im_q;
        v3_d = v3_q;  ovf_d = ovf_q;
        y_re_d = y_re_q;  y_im_d = y_im_q;
        z_re_d = z_re_q;  z_im_d = z_im_q;
        sticky_d = sticky_q;
        count_d  = count_q;

        adv_c      = !v3_q || bus.out_ready;
        out_xfer_c = v3_q && bus.out_ready;

        m_rr = PW'(bus.w_re) * PW'(bus.b_re);
        m_ii = PW'(bus.w_im) * PW'(bus.b_im);
        m_ri = PW'(bus.w_re) * PW'(bus.b_im);
        m_ir = PW'(bus.w_im) * PW'(bus.b_re);

        s_yr = SW'(a2_re_q) + p2_re_q;
        s_yi = SW'(a2_im_q) + p2_im_q;
        s_zr = SW'(a2_re_q) - p2_re_q;
        s_zi = SW'(a2_im_q) - p2_im_q;
        if (sc2_q) begin
            s_yr = s_yr >>> 1;
            s_yi = s_yi >>> 1;
            s_zr = s_zr >>> 1;
            s_zi = s_zi >>> 1;
        end
        {o_yr, y_re_d} = sat(s_yr);
        {o_yi, y_im_d} = sat(s_yi);
        {o_zr, z_re_d} = sat(s_zr);
        {o_zi, z_im_d} = sat(s_zi);

        if (adv_c) begin
            v1_d    = bus.in_valid;
            sc1_d   = bus.scale_en;
            a1_re_d = bus.a_re;
            a1_im_d = bus.a_im;
            p1_re_d = m_rr - m_ii;
            p1_im_d = m_ri + m_ir;

            v2_d    = v1_q;
            sc2_d   = sc1_q;
            a2_re_d = a1_re_q;
            a2_im_d = a1_im_q;
            p2_re_d = SW'((p1_re_q + RND) >>> (TW_W - 1));
            p2_im_d = SW'((p1_im_q + RND) >>> (TW_W - 1));

            v3_d  = v2_q;
            ovf_d = o_yr | o_yi | o_zr | o_zi;
        end

        // Result registers only reload with a real butterfly so idle outputs stay put.
        if (!(adv_c && v2_q)) begin
            y_re_d = y_re_q;  y_im_d = y_im_q;
            z_re_d = z_re_q;  z_im_d = z_im_q;
            ovf_d  = ovf_q;
        end

        // A saturated output leaving this cycle beats a simultaneous clear.
        if (out_xfer_c && ovf_q) begin
            sticky_d = 1'b1;
        end else if (bus.clr_ovf) begin
            sticky_d = 1'b0;
        end

        if (out_xfer_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q <= 1'b0;  sc1_q <= 1'b0;
            a1_re_q <= '0;  a1_im_q <= '0;
            p1_re_q <= '0;  p1_im_q <= '0;
            v2_q <= 1'b0;  sc2_q <= 1'b0;
            a2_re_q <= '0;  a2_im_q <= '0;
            p2_re_q <= '0;  p2_im_q <= '0;
            v3_q <= 1'b0;  ovf_q <= 1'b0;
            y_re_q <= '0;  y_im_q <= '0;
            z_re_q <= '0;  z_im_q <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            v1_q <= v1_d;  sc1_q <= sc1_d;
            a1_re_q <= a1_re_d;  a1_im_q <= a1_im_d;
            p1_re_q <= p1_re_d;  p1_im_q <= p1_im_d;
            v2_q <= v2_d;  sc2_q <= sc2_d;
            a2_re_q <= a2_re_d;  a2_im_q <= a2_im_d;
            p2_re_q <= p2_re_d;  p2_im_q <= p2_im_d;
            v3_q <= v3_d;  ovf_q <= ovf_d;
            y_re_q <= y_re_d;  y_im_q <= y_im_d;
            z_re_q <= z_re_d;  z_im_q <= z_im_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign bus.in_ready   = adv_c;
    assign bus.out_valid  = v3_q;
    assign bus.y_re       = y_re_q;
    assign bus.y_im       = y_im_q;
    assign bus.z_re       = z_re_q;
    assign bus.z_im       = z_im_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.out_count  = count_q;
endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Scoreboard bench for fft_butterfly_pipe: an integer reference model fills a queue
// at each input transfer, and each test task pops and compares at each output transfer.
module tb_fft_butterfly_pipe;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TW_W   = 8;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic signed [7:0] y_re;
        logic signed [7:0] y_im;
        logic signed [7:0] z_re;
        logic signed [7:0] z_im;
        logic              ovf;
    } res_t;

    logic clock = 1'b0;
    logic reset;
    res_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    fft_butterfly_pipe_if #(.DATA_W(DATA_W), .TW_W(TW_W), .CNT_W(CNT_W)) bus ();

    fft_butterfly_pipe #(.DATA_W(DATA_W), .TW_W(TW_W), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Integer reference: full-precision product, round half up, add, floor-halve, clamp.
    function automatic res_t model(input int ar, input int ai, input int br, input int bi,
                                   input int wr, input int wi, input bit sc);
        int   pr, pi;
        int   v[4];
        res_t r;
        pr = ((wr * br - wi * bi) + 64) >>> 7;
        pi = ((wr * bi + wi * br) + 64) >>> 7;
        v[0] = ar + pr;  v[1] = ai + pi;
        v[2] = ar - pr;  v[3] = ai - pi;
        r.ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sc) v[i] = v[i] >>> 1;
            if (v[i] > 127) begin
                v[i] = 127;  r.ovf = 1'b1;
            end else if (v[i] < -128) begin
                v[i] = -128; r.ovf = 1'b1;
            end
        end
        r.y_re = 8'(v[0]);  r.y_im = 8'(v[1]);
        r.z_re = 8'(v[2]);  r.z_im = 8'(v[3]);
        return r;
    endfunction

    task automatic drive(input int ar, input int ai, input int br, input int bi,
                         input int wr, input int wi, input bit sc);
        bus.a_re = 8'(ar);  bus.a_im = 8'(ai);
        bus.b_re = 8'(br);  bus.b_im = 8'(bi);
        bus.w_re = 8'(wr);  bus.w_im = 8'(wi);
        bus.scale_en = sc;
        bus.in_valid = 1'b1;
    endtask

    // One clock: sample handshakes at the falling edge, push expectation on input transfer.
    task automatic tick(output bit in_x, output bit out_x, output res_t obs);
        @(negedge clock);
        in_x  = !reset && bus.in_valid && bus.in_ready;
        out_x = bus.out_valid && bus.out_ready;
        obs.y_re = bus.y_re;  obs.y_im = bus.y_im;
        obs.z_re = bus.z_re;  obs.z_im = bus.z_im;
        obs.ovf  = bus.ovf;
        if (in_x)
            exp_q.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im,
                                  bus.w_re, bus.w_im, bus.scale_en));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;  bus.out_ready = 1'b1;  bus.clr_ovf = 1'b0;
        bus.scale_en = 1'b0;
        bus.a_re = '0;  bus.a_im = '0;  bus.b_re = '0;  bus.b_im = '0;
        bus.w_re = '0;  bus.w_im = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (bus.out_count !== 16'd0) begin
            failures++; $display("FAIL reset_out_count got=%0d exp=0", bus.out_count);
        end
        checks++;
        if ({bus.ovf, bus.ovf_sticky} !== 2'b00) begin
            failures++; $display("FAIL reset_ovf got=%b%b exp=00", bus.ovf, bus.ovf_sticky);
        end
        checks++;
        if ({bus.y_re, bus.y_im, bus.z_re, bus.z_im} !== 32'd0) begin
            failures++; $display("FAIL reset_yz got=%h exp=0",
                                 {bus.y_re, bus.y_im, bus.z_re, bus.z_im});
        end
        bus.out_ready = 1'b1;
    endtask

    // Directed vectors: ar ai br bi wr wi sc | y_re y_im z_re z_im ovf
    task automatic test_directed();
        int   tv[8][12] = '{
            '{  10,  5,   3,  -4, -128,    0, 0,    7,  9,  13,  1, 0},
            '{   0,  0,  20,  30,    0, -128, 0,   30,-20, -30, 20, 0},
            '{   0,  0,   1,   0,  127,    0, 0,    1,  0,  -1,  0, 0},
            '{   0,  0,  -1,   0,  127,    0, 0,   -1,  0,   1,  0, 0},
            '{ -50, 60, -70,  45,   90,  -77, 1,  -36, 67, -14, -7, 0},
            '{ 127,  0, 100,   0, -128,    0, 0,   27,  0, 127,  0, 1},
            '{ 127,  0, 100,   0, -128,    0, 1,   13,  0, 113,  0, 0},
            '{-128,  0, 100,   0, -128,    0, 0, -128,  0, -28,  0, 1}};
        bit   in_x, out_x, sticky_exp;
        res_t obs, exp_m, exp_t;
        int   n;
        do_reset();
        sticky_exp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5], tv[i][6] != 0);
            tick(in_x, out_x, obs);
            bus.in_valid = 1'b0;
            n = 1;
            while (!out_x && n < 10) begin
                tick(in_x, out_x, obs);
                n++;
            end
            checks++;
            if (!out_x || exp_q.size() == 0) begin
                failures++; $display("FAIL dir%0d_no_output ticks=%0d queued=%0d", i, n, exp_q.size());
                continue;
            end
            exp_m = exp_q.pop_front();
            exp_t = {8'(tv[i][7]), 8'(tv[i][8]), 8'(tv[i][9]), 8'(tv[i][10]), tv[i][11] != 0};
            if (n != 4) begin
                failures++; $display("FAIL dir%0d_latency got=%0d exp=4", i, n);
            end
            checks++;
            if (obs !== exp_t) begin
                failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, obs, exp_t);
            end
            checks++;
            if (obs !== exp_m) begin
                failures++; $display("FAIL dir%0d_model got=%h exp=%h", i, obs, exp_m);
            end
            sticky_exp |= exp_t.ovf;
            checks++;
            if (bus.ovf_sticky !== sticky_exp) begin
                failures++; $display("FAIL dir%0d_sticky got=%b exp=%b", i, bus.ovf_sticky, sticky_exp);
            end
        end
        bus.clr_ovf = 1'b1;
        tick(in_x, out_x, obs);
        bus.clr_ovf = 1'b0;
        checks++;
        if (bus.ovf_sticky !== 1'b0) begin
            failures++; $display("FAIL clr_ovf got=%b exp=0", bus.ovf_sticky);
        end
    endtask

    // Set beats clear: clr_ovf held high while a saturating result leaves.
    task automatic test_ovf_priority();
        bit   in_x, out_x;
        res_t obs;
        int   n;
        bus.clr_ovf = 1'b1;
        drive(127, 0, 100, 0, -128, 0, 0);
        tick(in_x, out_x, obs);
        bus.in_valid = 1'b0;
        n = 1;
        while (!out_x && n < 10) begin
            tick(in_x, out_x, obs);
            n++;
        end
        exp_q.delete();
        checks++;
        if (!out_x || bus.ovf_sticky !== 1'b1) begin
            failures++; $display("FAIL ovf_set_wins got=%b exp=1 out=%b", bus.ovf_sticky, out_x);
        end
        tick(in_x, out_x, obs);
        bus.clr_ovf = 1'b0;
        checks++;
        if (bus.ovf_sticky !== 1'b0) begin
            failures++; $display("FAIL ovf_clear_after got=%b exp=0", bus.ovf_sticky);
        end
    endtask

    task automatic test_backpressure();
        bit   in_x, out_x;
        res_t obs, held, e;
        int   n_in, n_out;
        do_reset();
        bus.out_ready = 1'b0;
        n_in = 0;
        drive(11, -7, 33, 90, 100, -60, 0);
        for (int i = 0; i < 6; i++) begin
            tick(in_x, out_x, obs);
            if (in_x) begin
                n_in++;
                drive(11 + 20 * n_in, -7 * n_in, 33 - n_in, 90, 100, -60, n_in[0]);
            end
        end
        checks++;
        if (n_in != 3) begin
            failures++; $display("FAIL bp_accepted got=%0d exp=3", n_in);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready);
        end
        held = {bus.y_re, bus.y_im, bus.z_re, bus.z_im, bus.ovf};
        repeat (2) tick(in_x, out_x, obs);
        checks++;
        if (obs !== held) begin
            failures++; $display("FAIL bp_hold got=%h exp=%h", obs, held);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_out = 0;
        for (int i = 0; i < 10; i++) begin
            tick(in_x, out_x, obs);
            if (out_x) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra_output got=%h", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        failures++; $display("FAIL bp_drain%0d got=%h exp=%h", n_out, obs, e);
                    end
                end
            end
        end
        checks++;
        if (n_out != 3 || bus.out_count !== 16'd3) begin
            failures++; $display("FAIL bp_count got=%0d/%0d exp=3/3", n_out, bus.out_count);
        end
    endtask

    task automatic test_random();
        bit   in_x, out_x;
        res_t obs, e;
        int   n_out, bad;
        do_reset();
        bus.in_valid = 1'b0;
        n_out = 0;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            if (c >= 360) bus.in_valid = 1'b0;
            else if (!bus.in_valid || in_x) begin
                if ($urandom_range(0, 9) < 7)
                    drive($signed(8'($urandom_range(0, 255))), $signed(8'($urandom_range(0, 255))),
                          $signed(8'($urandom_range(0, 255))), $signed(8'($urandom_range(0, 255))),
                          $signed(8'($urandom_range(0, 255))), $signed(8'($urandom_range(0, 255))),
                          1'($urandom_range(0, 1)));
                else
                    bus.in_valid = 1'b0;
            end
            bus.out_ready = (c >= 360) || ($urandom_range(0, 9) < 7);
            tick(in_x, out_x, obs);
            if (out_x) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_extra_output got=%h", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        failures++;
                        if (bad++ < 10) $display("FAIL rnd_result n=%0d got=%h exp=%h", n_out, obs, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || bus.out_count !== 16'(n_out)) begin
            failures++; $display("FAIL rnd_count got=%0d exp=%0d left=%0d",
                                 bus.out_count, n_out, exp_q.size());
        end
    endtask

    task automatic test_reset_flight();
        bit   in_x, out_x;
        res_t obs;
        int   n_out;
        do_reset();
        drive(1, 2, 3, 4, 5, 6, 0);
        tick(in_x, out_x, obs);
        drive(7, 8, 9, 10, 11, 12, 0);
        tick(in_x, out_x, obs);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick(in_x, out_x, obs);
        reset = 1'b0;
        exp_q.delete();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_count !== 16'd0) begin
            failures++; $display("FAIL flush_state in_ready=%b count=%0d exp=1/0",
                                 bus.in_ready, bus.out_count);
        end
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            tick(in_x, out_x, obs);
            if (bus.out_valid || out_x) n_out++;
        end
        checks++;
        if (n_out != 0 || bus.out_count !== 16'd0) begin
            failures++; $display("FAIL flush_outputs got=%0d count=%0d exp=0/0", n_out, bus.out_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_directed();
        test_ovf_priority();
        test_backpressure();
        test_random();
        test_reset_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_butterfly_pipe.md
Name: fft_butterfly_pipe

Overview:
Parametrised, pipelined radix-2 decimation-in-time butterfly. It is the streaming successor to the switch-driven single-butterfly FFT datapath: complex inputs, generic data and twiddle widths, optional per-stage 1/2 scaling, saturation with overflow reporting, and valid/ready flow control. It sits between a sample/twiddle sequencer and downstream FFT stages or display logic. It computes y = a + W·b and z = a − W·b, one butterfly per clock.

Parameters:
DATA_W, 8, signed two's-complement width of a, b, y, z components
TW_W, 8, signed twiddle width, Q1.(TW_W-1); −2^(TW_W-1) represents exactly −1
CNT_W, 16, width of the output butterfly counter

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input butterfly operands valid
in_ready  out  1  block can accept operands this cycle
a_re, a_im  in  DATA_W each  operand a
b_re, b_im  in  DATA_W each  operand b
w_re, w_im  in  TW_W each  twiddle factor W
scale_en  in  1  when 1, results are arithmetically shifted right by 1; sampled with the operands
clr_ovf  in  1  clears the sticky overflow flag
out_valid  out  1  y/z valid
out_ready  in  1  downstream accepts y/z
y_re, y_im, z_re, z_im  out  DATA_W each  results
ovf  out  1  result of the current output saturated (qualified by out_valid)
ovf_sticky  out  1  set on any accepted saturated output; cleared by reset or clr_ovf
out_count  out  CNT_W  number of accepted outputs, wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous, active-high): all stage valids = 0, out_valid = 0, in_ready = 1 on the first cycle after reset deasserts, y/z = 0, ovf = 0, ovf_sticky = 0, out_count = 0. Reset mid-operation discards all in-flight butterflies without producing output.
- 3-stage pipeline. Each stage register holds data, scale_en and a valid bit.
- Global advance enable: adv = !v3 || out_ready. in_ready = adv. An input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready. out_valid = v3.
- Latency: 3 cycles from input transfer to out_valid, with out_ready held high. Throughput is 1 butterfly per cycle. Capacity is 3 butterflies. Bubbles are not collapsed.
- S1: p_re = w_re·b_re − w_im·b_im; p_im = w_re·b_im + w_im·b_re. Full precision is DATA_W+TW_W+1 bits signed. a is carried along.
- S2: round to DATA_W+2 bits by adding 2^(TW_W-2), then arithmetic shift right by (TW_W−1) (round half up).
- S3: y = a + p and z = a − p at DATA_W+2 bits. If scale_en, arithmetic shift right by 1 (floor). Each component then saturates to [−2^(DATA_W-1), 2^(DATA_W-1)−1]. ovf = OR of the four component saturations.
- ovf_sticky sets on an output transfer with ovf = 1. When clr_ovf and a set event occur in the same cycle, the set event wins.
- out_count increments on each output transfer and wraps from 2^CNT_W−1 to 0.
- While out_valid && !out_ready, the y/z/ovf outputs hold stable, and stages S1–S2 hold their contents.
- If in_valid is asserted while in_ready = 0, the input is ignored. The source must hold it.

Test Plan:
- W=−1 (w_re=−128, w_im=0), a=(10,5), b=(3,−4), scale_en=0 → 3 cycles later y=(7,9), z=(13,1), ovf=0.
- W=−j (w_re=0, w_im=−128), a=(0,0), b=(20,30) → y=(30,−20), z=(−30,20).
- Saturation: W=−1, a=(127,0), b=(100,0), scale_en=0 → y_re=27, z_re=127, ovf=1, ovf_sticky=1. Repeat with scale_en=1 → y_re=13, z_re=113, ovf=0, and ovf_sticky stays 1 until a clr_ovf pulse.
- Rounding: W=(127,0), a=0, b=(1,0) → y_re=1. b=(−1,0) → y_re=−1, z_re=1.
- Backpressure: out_ready=0 with in_valid held high → exactly 3 transfers accepted, then in_ready=0. Raising out_ready drains outputs in order with no loss or duplication, and out_count=3 afterwards.
- Reset pulse with 2 butterflies in flight → no out_valid afterwards, out_count=0, in_ready=1 on the next cycle.
